// File: rtl/video_mux_pkg.sv
// Shared types and helpers for the video source multiplexer.
//   pix_fmt_e : per-channel pixel format code (2 bits, as packed in CH_FMT)
//   state_e   : switch sequencer state
//   to_rgb888 : expands one pixel of a given format to 24-bit {R,G,B}
package video_mux_pkg;

    typedef enum logic [1:0] {
        FMT_RGB565 = 2'd0,
        FMT_MONO1  = 2'd1,
        FMT_GRAY8  = 2'd2,
        FMT_RGB888 = 2'd3
    } pix_fmt_e;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_VS = 2'd1,
        ALIGN   = 2'd2
    } state_e;

    // Low colour bits are zero-filled, not replicated, so RGB565 white is F8FCF8.
    function automatic logic [23:0] to_rgb888(input pix_fmt_e fmt, input logic [23:0] d);
        logic [23:0] res;
        case (fmt)
            FMT_RGB565: res = {d[15:11], 3'b0, d[10:5], 2'b0, d[4:0], 3'b0};
            FMT_MONO1:  res = d[0] ? 24'hFFFFFF : 24'h0;
            FMT_GRAY8:  res = {d[7:0], d[7:0], d[7:0]};
            default:    res = d;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/video_src_mux_key_debounce.sv
// Push-button front end for the source selector (built only when
// VIDEO_SRC_MUX_KEY_EN is defined).
//   clk, rst  : pixel clock, async active-high reset
//   key_n     : raw active-low button, asynchronous to clk
//   press     : 1-cycle pulse when a press has been stable for DEBOUNCE_CYC cycles
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;

    // The counter runs only while the synchronised level disagrees with the
    // accepted level; any bounce back restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= 2'b11;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            press    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], key_n};
            press  <= 1'b0;
            if (r_sync[1] != r_stable) begin
                if (r_cnt == CNT_MAX) begin
                    r_stable <= r_sync[1];
                    r_cnt    <= '0;
                    press    <= ~r_sync[1];
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/video_src_mux.sv
// Frame-aligned N-channel video source selector with per-channel conversion
// to RGB888. A switch request waits for the next frame start of the current
// source, commits, then blanks DE/data until the new source starts a frame.
// A watchdog forces progress if a source has no vsync.
// Optional feature: define VIDEO_SRC_MUX_KEY_EN to add a debounced key_n
// button that steps to the next channel.
//   clk, rst           : pixel clock, async active-high reset
//   key_n              : (VIDEO_SRC_MUX_KEY_EN only) active-low button
//   sel_req/sel_valid  : requested channel and its 1-cycle strobe
//   in_hs/in_vs/in_de  : per-channel syncs and data enable
//   in_data            : per-channel pixel, 24-bit lane each
//   out_hs/vs/de/data  : registered output of the active channel, RGB888
//   sel_cur            : channel currently driving the outputs
//   sel_busy           : switch pending or in progress
module video_src_mux #(
    parameter int          CH_NUM       = 4,
    parameter logic [31:0] CH_FMT       = 32'h0,
    parameter int          INIT_SEL     = 0,
    parameter int          VS_TIMEOUT   = 2**22,
`ifdef VIDEO_SRC_MUX_KEY_EN
    parameter int          DEBOUNCE_CYC = 1_000_000,
`endif
    parameter int          SEL_W        = $clog2(CH_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef VIDEO_SRC_MUX_KEY_EN
    input  logic                 key_n,
`endif
    input  logic [SEL_W-1:0]     sel_req,
    input  logic                 sel_valid,
    input  logic [CH_NUM-1:0]    in_hs,
    input  logic [CH_NUM-1:0]    in_vs,
    input  logic [CH_NUM-1:0]    in_de,
    input  logic [CH_NUM*24-1:0] in_data,
    output logic                 out_hs,
    output logic                 out_vs,
    output logic                 out_de,
    output logic [23:0]          out_data,
    output logic [SEL_W-1:0]     sel_cur,
    output logic                 sel_busy
);
    import video_mux_pkg::*;

    // Lanes padded to a power of two so the select indexes them exactly.
    localparam int NPAD = 1 << SEL_W;
    localparam int WD_W = (VS_TIMEOUT > 1) ? $clog2(VS_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(VS_TIMEOUT - 1);

    logic [NPAD-1:0] w_hs, w_vs, w_de, w_fs;
    logic [23:0]     w_pix [NPAD];
    pix_fmt_e        w_fmt [NPAD];

    for (genvar g = 0; g < NPAD; g++) begin : g_lane
        if (g < CH_NUM) begin : g_real
            assign w_hs[g]  = in_hs[g];
            assign w_vs[g]  = in_vs[g];
            assign w_de[g]  = in_de[g];
            assign w_pix[g] = in_data[24*g +: 24];
            assign w_fmt[g] = pix_fmt_e'(CH_FMT[2*g +: 2]);
        end else begin : g_pad
            assign w_hs[g]  = 1'b0;
            assign w_vs[g]  = 1'b0;
            assign w_de[g]  = 1'b0;
            assign w_pix[g] = '0;
            assign w_fmt[g] = FMT_RGB888;
        end
    end

    state_e          r_state;
    logic [SEL_W-1:0] r_sel_cur, r_pend_sel;
    logic            r_pend;
    logic [WD_W-1:0] r_wdog;
    logic [NPAD-1:0] r_vs_d;
    logic            r_hs_p1, r_vs_p1, r_vld_p1;
    logic [23:0]     r_data_p1;

    logic             w_fs_cur, w_wd_to, w_commit, w_eff_pend, w_accept, w_req_v;
    logic [SEL_W-1:0] w_eff_cur, w_req_sel;

    assign w_fs     = w_vs & ~r_vs_d;
    assign w_fs_cur = w_fs[r_sel_cur];
    assign w_wd_to  = (r_wdog == WD_MAX);

`ifdef VIDEO_SRC_MUX_KEY_EN
    logic             w_key_press;
    logic [SEL_W-1:0] w_key_base, w_key_sel;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_n),
        .press (w_key_press)
    );

    // Step from the channel we are heading to, so repeated presses accumulate.
    assign w_key_base = r_pend ? r_pend_sel : r_sel_cur;
    assign w_key_sel  = (int'(w_key_base) == CH_NUM - 1) ? '0 : w_key_base + SEL_W'(1);
`endif

    // A request landing on the commit cycle is judged against the state
    // after the commit: the new sel_cur with nothing pending.
    always_comb begin
        w_req_v   = sel_valid;
        w_req_sel = sel_req;
`ifdef VIDEO_SRC_MUX_KEY_EN
        if (!sel_valid && w_key_press) begin
            w_req_v   = 1'b1;
            w_req_sel = w_key_sel;
        end
`endif
        w_commit   = (r_state == WAIT_VS) && (w_fs_cur || w_wd_to);
        w_eff_cur  = w_commit ? r_pend_sel : r_sel_cur;
        w_eff_pend = r_pend && !w_commit;
        w_accept   = w_req_v && (int'(w_req_sel) < CH_NUM)
                     && !((w_req_sel == w_eff_cur) && !w_eff_pend);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_sel_cur  <= SEL_W'(INIT_SEL);
            r_pend_sel <= '0;
            r_pend     <= 1'b0;
            r_wdog     <= '0;
            r_vs_d     <= '0;
            r_hs_p1    <= 1'b0;
            r_vs_p1    <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_data_p1  <= '0;
        end else begin
            r_vs_d <= w_vs;

            if (w_accept) begin
                r_pend     <= 1'b1;
                r_pend_sel <= w_req_sel;
            end else if (w_commit) begin
                r_pend <= 1'b0;
            end

            case (r_state)
                RUN: begin
                    r_wdog <= '0;
                    if (r_pend) r_state <= WAIT_VS;
                end
                WAIT_VS: begin
                    if (w_commit) begin
                        r_sel_cur <= r_pend_sel;
                        r_state   <= ALIGN;
                        r_wdog    <= '0;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
                ALIGN: begin
                    if (w_fs_cur || w_wd_to) begin
                        r_state <= RUN;
                        r_wdog  <= '0;
                    end else begin
                        r_wdog <= r_wdog + WD_W'(1);
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_wdog  <= '0;
                end
            endcase

            // ---- output stage p1: one clock after the selected inputs ----
            r_hs_p1 <= w_hs[r_sel_cur];
            r_vs_p1 <= w_vs[r_sel_cur];
            // Blank while aligning, but let the frame-start pixel through.
            if ((r_state == ALIGN) && !w_fs_cur) begin
                r_vld_p1  <= 1'b0;
                r_data_p1 <= '0;
            end else begin
                r_vld_p1  <= w_de[r_sel_cur];
                r_data_p1 <= to_rgb888(w_fmt[r_sel_cur], w_pix[r_sel_cur]);
            end
        end
    end

    assign out_hs   = r_hs_p1;
    assign out_vs   = r_vs_p1;
    assign out_de   = r_vld_p1;
    assign out_data = r_data_p1;
    assign sel_cur  = r_sel_cur;
    assign sel_busy = (r_state != RUN) | r_pend;

endmodule

// File: tb/tb_video_src_mux.sv
module tb_video_src_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sel_req;
    logic        sel_valid;
    logic [3:0]  in_hs, in_vs, in_de;
    logic [95:0] in_data;
    logic        out_hs, out_vs, out_de;
    logic [23:0] out_data;
    logic [2:0]  sel_cur;
    logic        sel_busy;
`ifdef VIDEO_SRC_MUX_KEY_EN
    logic        key_n;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    video_src_mux #(
        .CH_NUM     (4),
        .CH_FMT     (32'hE4),
        .INIT_SEL   (0),
        .VS_TIMEOUT (64),
`ifdef VIDEO_SRC_MUX_KEY_EN
        .DEBOUNCE_CYC (16),
`endif
        .SEL_W      (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef VIDEO_SRC_MUX_KEY_EN
        .key_n     (key_n),
`endif
        .sel_req   (sel_req),
        .sel_valid (sel_valid),
        .in_hs     (in_hs),
        .in_vs     (in_vs),
        .in_de     (in_de),
        .in_data   (in_data),
        .out_hs    (out_hs),
        .out_vs    (out_vs),
        .out_de    (out_de),
        .out_data  (out_data),
        .sel_cur   (sel_cur),
        .sel_busy  (sel_busy)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic hs, input logic vs, input logic de,
                          input logic [23:0] d);
        in_hs[c] = hs;
        in_vs[c] = vs;
        in_de[c] = de;
        in_data[24*c +: 24] = d;
    endtask

    task automatic request(input logic [2:0] ch);
        sel_req   = ch;
        sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
    endtask

`ifdef VIDEO_SRC_MUX_KEY_EN
    // One frame start on every channel.
    task automatic frame_pulse();
        in_vs = 4'h0; step();
        in_vs = 4'hF; step();
        in_vs = 4'h0; step();
    endtask

    task automatic press_key(input int low_cyc);
        key_n = 1'b0; step(low_cyc);
        key_n = 1'b1; step(30);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // T1: reset held with ch0 active
        rst = 1'b1; sel_req = '0; sel_valid = 1'b0;
        in_hs = '0; in_vs = '0; in_de = '0; in_data = '0;
`ifdef VIDEO_SRC_MUX_KEY_EN
        key_n = 1'b1;
`endif
        set_ch(0, 1'b1, 1'b1, 1'b1, 24'h00F81F);
        step(2);
        chk("rst_de",   {23'b0, out_de}, 24'h0);
        chk("rst_hs",   {23'b0, out_hs}, 24'h0);
        chk("rst_vs",   {23'b0, out_vs}, 24'h0);
        chk("rst_data", out_data, 24'h0);
        chk("rst_sel",  {21'b0, sel_cur}, 24'h0);
        chk("rst_busy", {23'b0, sel_busy}, 24'h0);
        rst = 1'b0;
        step();
        chk("t1_de",   {23'b0, out_de}, 24'h1);
        chk("t1_hsvs", {22'b0, out_hs, out_vs}, 24'h3);
        chk("t1_rgb565", out_data, 24'hF800F8);

        set_ch(0, 1'b0, 1'b0, 1'b0, 24'h0007E0);
        step();
        chk("t2_rgb565_g", out_data, 24'h00FC00);
        chk("t2_de0", {23'b0, out_de}, 24'h0);

        // T3: switch to ch2 mid-frame of ch0
        set_ch(0, 1'b0, 1'b0, 1'b1, 24'h00F81F);
        set_ch(2, 1'b0, 1'b0, 1'b1, 24'h00005A);
        step();
        request(3'd2);
        chk("t3_busy_req", {23'b0, sel_busy}, 24'h1);
        chk("t3_sel_hold", {21'b0, sel_cur}, 24'h0);
        step(3);
        chk("t3_ch0_cont", out_data, 24'hF800F8);
        chk("t3_sel_wait", {21'b0, sel_cur}, 24'h0);
        in_vs[0] = 1'b1;
        step();
        chk("t3_sel_commit", {21'b0, sel_cur}, 24'h2);
        chk("t3_last_ch0",   out_data, 24'hF800F8);
        chk("t3_vs_ch0",     {23'b0, out_vs}, 24'h1);
        in_vs[0] = 1'b0;
        step();
        chk("t3_align_de",   {23'b0, out_de}, 24'h0);
        chk("t3_align_data", out_data, 24'h0);
        chk("t3_align_busy", {23'b0, sel_busy}, 24'h1);
        step();
        chk("t3_align_de2",  {23'b0, out_de}, 24'h0);
        in_vs[2] = 1'b1;
        step();
        chk("t3_gray8",      out_data, 24'h5A5A5A);
        chk("t3_first_de",   {23'b0, out_de}, 24'h1);
        chk("t3_first_vs",   {23'b0, out_vs}, 24'h1);
        in_vs[2] = 1'b0;
        step();
        chk("t3_idle_busy",  {23'b0, sel_busy}, 24'h0);
        chk("t3_sel_final",  {21'b0, sel_cur}, 24'h2);

        // T4: 1 then 3 within one frame, only 3 lands
        set_ch(3, 1'b0, 1'b0, 1'b1, 24'h123456);
        request(3'd1);
        request(3'd3);
        step(2);
        chk("t4_busy", {23'b0, sel_busy}, 24'h1);
        in_vs[2] = 1'b1;
        step();
        chk("t4_sel_commit", {21'b0, sel_cur}, 24'h3);
        step();
        chk("t4_align_de", {23'b0, out_de}, 24'h0);
        in_vs[3] = 1'b1;
        step();
        chk("t4_rgb888", out_data, 24'h123456);
        in_vs[3] = 1'b0; in_vs[2] = 1'b0;
        step();
        chk("t4_idle", {23'b0, sel_busy}, 24'h0);
        request(3'd7);
        chk("t4_illegal_busy", {23'b0, sel_busy}, 24'h0);
        step();
        chk("t4_illegal_busy2", {23'b0, sel_busy}, 24'h0);
        chk("t4_illegal_sel", {21'b0, sel_cur}, 24'h3);
        request(3'd3);
        chk("t4_same_busy", {23'b0, sel_busy}, 24'h0);

        // T5: watchdog with dead vsync on ch3 and ch1
        set_ch(1, 1'b0, 1'b0, 1'b1, 24'h000001);
        request(3'd1);
        step(64);
        chk("t5_wd_hold", {21'b0, sel_cur}, 24'h3);
        step();
        chk("t5_wd_commit", {21'b0, sel_cur}, 24'h1);
        step(63);
        chk("t5_align_busy", {23'b0, sel_busy}, 24'h1);
        chk("t5_align_de",   {23'b0, out_de}, 24'h0);
        step();
        chk("t5_run_busy", {23'b0, sel_busy}, 24'h0);
        step();
        chk("t5_mono1", out_data, 24'hFFFFFF);
        in_data[24 +: 24] = 24'hFFFFFE;
        step();
        chk("t5_mono0", out_data, 24'h000000);

        // Async reset mid-switch drops the pending request
        request(3'd2);
        chk("ar_busy_pre", {23'b0, sel_busy}, 24'h1);
        rst = 1'b1;
        #1;
        chk("ar_sel",  {21'b0, sel_cur}, 24'h0);
        chk("ar_busy", {23'b0, sel_busy}, 24'h0);
        chk("ar_de",   {23'b0, out_de}, 24'h0);
        step();
        rst = 1'b0;
        step(3);
        chk("ar_lost_busy", {23'b0, sel_busy}, 24'h0);
        chk("ar_lost_sel",  {21'b0, sel_cur}, 24'h0);

`ifdef VIDEO_SRC_MUX_KEY_EN
        // T6: key stepping from ch3
        request(3'd3);
        step();
        frame_pulse();
        frame_pulse();
        chk("t6_start", {21'b0, sel_cur}, 24'h3);
        key_n = 1'b0; step(10);
        key_n = 1'b1; step(40);
        chk("t6_glitch_busy", {23'b0, sel_busy}, 24'h0);
        chk("t6_glitch_sel",  {21'b0, sel_cur}, 24'h3);
        for (int p = 0; p < 3; p++) begin
            press_key(30);
            frame_pulse();
            frame_pulse();
        end
        chk("t6_final_sel",  {21'b0, sel_cur}, 24'h2);
        chk("t6_final_busy", {23'b0, sel_busy}, 24'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
